// File: rtl/multi_cycle_proc.sv
// multi_cycle_proc: multi-cycle LEGv8-subset processor core.
//   Supports ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B. Each instruction walks a
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] sequence. An unknown opcode parks the
//   core in HALT until reset. Register NREGS-1 is the hard-wired zero register.
// Ports:
//   CLK, Reset_L          clock, asynchronous active-low reset
//   startPC / currentPC   PC loaded on reset / address of instruction in progress
//   imem_req/ack/rdata    instruction fetch handshake (address is currentPC)
//   dmem_*                data memory handshake (req held until ack)
//   dMemOut               last loaded data word
//   retire, halted        per-instruction completion pulse, HALT indicator
//   cycle_cnt, instr_cnt  performance counters
// Configuration:
//   MCPROC_PERF_CNT_EN    when defined, builds the cycle/instruction counters;
//                         otherwise both counter outputs are tied to zero.
module multi_cycle_proc #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 32
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic [DATA_W-1:0] startPC,
  output logic [DATA_W-1:0] currentPC,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] dMemOut,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
);

  localparam int unsigned RegAW = $clog2(NREGS);
  localparam logic [RegAW-1:0] ZeroReg = RegAW'(NREGS - 1);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [3:0] {OpAdd, OpSub, OpAnd, OpOrr, OpLdur, OpStur, OpCbz, OpB, OpBad} op_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_dmem_out;
  logic [DATA_W-1:0] r_regs [NREGS];

  op_e               w_op;
  logic [RegAW-1:0]  w_rd;
  logic [RegAW-1:0]  w_rn;
  logic [RegAW-1:0]  w_rm;
  logic [RegAW-1:0]  w_rb_sel;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_imm9;
  logic [DATA_W-1:0] w_br19;
  logic [DATA_W-1:0] w_br26;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_next_pc;
  logic              w_is_branch;
  logic              w_is_mem;

  // Opcode decode; r_instr is stable from DECODE until the instruction retires.
  always_comb begin
    w_op = OpBad;
    if      (r_instr[31:21] == 11'b10001011000) w_op = OpAdd;
    else if (r_instr[31:21] == 11'b11001011000) w_op = OpSub;
    else if (r_instr[31:21] == 11'b10001010000) w_op = OpAnd;
    else if (r_instr[31:21] == 11'b10101010000) w_op = OpOrr;
    else if (r_instr[31:21] == 11'b11111000010) w_op = OpLdur;
    else if (r_instr[31:21] == 11'b11111000000) w_op = OpStur;
    else if (r_instr[31:24] == 8'b10110100)     w_op = OpCbz;
    else if (r_instr[31:26] == 6'b000101)       w_op = OpB;
  end

  assign w_is_branch = (w_op == OpCbz) || (w_op == OpB);
  assign w_is_mem    = (w_op == OpLdur) || (w_op == OpStur);

  assign w_rd = r_instr[0 +: RegAW];
  assign w_rn = r_instr[5 +: RegAW];
  assign w_rm = r_instr[16 +: RegAW];
  // STUR and CBZ take their second operand from the Rt field.
  assign w_rb_sel = ((w_op == OpStur) || (w_op == OpCbz)) ? w_rd : w_rm;

  assign w_rf_a = (w_rn == ZeroReg) ? '0 : r_regs[w_rn];
  assign w_rf_b = (w_rb_sel == ZeroReg) ? '0 : r_regs[w_rb_sel];

  assign w_imm9 = {{(DATA_W-9){r_instr[20]}}, r_instr[20:12]};
  assign w_br19 = {{(DATA_W-21){r_instr[23]}}, r_instr[23:5], 2'b00};
  assign w_br26 = {{(DATA_W-28){r_instr[25]}}, r_instr[25:0], 2'b00};

  always_comb begin
    w_alu = r_a + r_b;
    case (w_op)
      OpSub:          w_alu = r_a - r_b;
      OpAnd:          w_alu = r_a & r_b;
      OpOrr:          w_alu = r_a | r_b;
      OpLdur, OpStur: w_alu = r_a + w_imm9;
      default:        w_alu = r_a + r_b;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc + DATA_W'(4);
    if (w_op == OpB) begin
      w_next_pc = r_pc + w_br26;
    end else if ((w_op == OpCbz) && (r_b == '0)) begin
      w_next_pc = r_pc + w_br19;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state    <= StFetch;
      r_pc       <= startPC;
      r_instr    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu      <= '0;
      r_mdr      <= '0;
      r_dmem_out <= '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StFetch: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          if (w_op == OpBad) begin
            r_state <= StHalt;
          end else begin
            r_a     <= w_rf_a;
            r_b     <= w_rf_b;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_alu <= w_alu;
          if (w_is_branch) begin
            r_pc    <= w_next_pc;
            r_state <= StFetch;
          end else if (w_is_mem) begin
            r_state <= StMem;
          end else begin
            r_state <= StWb;
          end
        end
        StMem: begin
          if (dmem_ack) begin
            if (w_op == OpLdur) begin
              r_mdr   <= dmem_rdata;
              r_state <= StWb;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= StFetch;
            end
          end
        end
        StWb: begin
          if (w_rd != ZeroReg) begin
            r_regs[w_rd] <= (w_op == OpLdur) ? r_mdr : r_alu;
          end
          if (w_op == OpLdur) begin
            r_dmem_out <= r_mdr;
          end
          r_pc    <= w_next_pc;
          r_state <= StFetch;
        end
        StHalt: begin
          r_state <= StHalt;
        end
        default: r_state <= StHalt;
      endcase
    end
  end

  // State is FETCH during reset, so the fetch request is masked by Reset_L.
  assign imem_req   = Reset_L && (r_state == StFetch);
  assign dmem_req   = (r_state == StMem);
  assign dmem_we    = (r_state == StMem) && (w_op == OpStur);
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_b;
  assign dMemOut    = r_dmem_out;
  assign currentPC  = r_pc;
  assign halted     = (r_state == StHalt);
  assign retire     = ((r_state == StExec) && w_is_branch) ||
                      ((r_state == StMem) && dmem_ack && (w_op == OpStur)) ||
                      (r_state == StWb);

`ifdef MCPROC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != StHalt) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (retire) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_proc.sv
// tb_multi_cycle_proc: directed self-checking bench for multi_cycle_proc.
module tb_multi_cycle_proc;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] startPC;
  logic [63:0] currentPC;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic [63:0] dMemOut;
  logic        retire;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int          checks;
  int          errors;
  logic [63:0] mem [16];
  logic [63:0] last_addr;
  logic [63:0] last_wdata;
  logic [63:0] exp_pc;

  multi_cycle_proc dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .startPC   (startPC),
    .currentPC (currentPC),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ack  (dmem_ack),
    .dMemOut   (dMemOut),
    .retire    (retire),
    .halted    (halted),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [4:0] rt,
                                        input logic [4:0] rn, input logic [8:0] imm);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'b10110100, imm, rt};
  endfunction

  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  // Runs one instruction from its first (FETCH) cycle; acts as data memory with
  // ack_dly wait cycles. Returns cycles to retire and cycles dmem_req was high.
  task automatic run_instr(input logic [31:0] ins, input int ack_dly,
                           output int ncyc, output int nreq);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    nreq = 0;
    imem_rdata = ins;
    while (!done && cyc < 50) begin
      cyc++;
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) begin
        if (nreq == ack_dly) begin
          dmem_ack  = 1'b1;
          last_addr = dmem_addr;
          if (dmem_we) begin
            mem[dmem_addr[6:3]] = dmem_wdata;
            last_wdata = dmem_wdata;
          end else begin
            dmem_rdata = mem[dmem_addr[6:3]];
          end
        end
        nreq++;
      end
      #1;
      if (retire) done = 1'b1;
      @(negedge CLK);
    end
    dmem_ack = 1'b0;
    ncyc = done ? cyc : -1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_instr_timeout ins=%h got no retire in 50 cycles", ins);
    end
  endtask

  task automatic do_reset(input logic [63:0] pc);
    @(negedge CLK);
    Reset_L  = 1'b0;
    startPC  = pc;
    dmem_ack = 1'b0;
    #2;
    @(negedge CLK);
    Reset_L = 1'b1;
    exp_pc  = pc;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    Reset_L = 1'b0;
    startPC = 64'h100;
    #1;
    checks++;
    if (currentPC !== 64'h100) begin
      errors++; $display("FAIL reset_pc got %h want %h", currentPC, 64'h100);
    end
    checks++;
    if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000",
                         {imem_req, dmem_req, dmem_we, retire, halted});
    end
    checks++;
    if (dMemOut !== 64'h0 || cycle_cnt !== 32'h0 || instr_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_data dMemOut=%h cyc=%h ins=%h want 0", dMemOut,
                         cycle_cnt, instr_cnt);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    exp_pc  = 64'h100;
  endtask

  task automatic test_add;
    int nc, nr;
    run_instr(enc_r(OP_ADD, 5'd1, 5'd31, 5'd31), 0, nc, nr);
    exp_pc += 64'd4;
    checks++;
    if (nc !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", nc); end
    checks++;
    if (currentPC !== 64'h104) begin
      errors++; $display("FAIL add_pc got %h want %h", currentPC, 64'h104);
    end
    run_instr(enc_d(OP_STUR, 5'd1, 5'd31, 9'd24), 0, nc, nr);
    exp_pc += 64'd4;
    checks++;
    if (nc !== 4 || last_addr !== 64'd24 || last_wdata !== 64'd0) begin
      errors++; $display("FAIL stur_x1 got cyc=%0d addr=%h data=%h want 4/18/0", nc,
                         last_addr, last_wdata);
    end
  endtask

  task automatic test_alu;
    int nc, nr;
    logic [63:0] exp_w [5];
    logic [10:0] ops   [5];
    logic [4:0]  dsts  [5];
    exp_w[0] = 64'd17;  ops[0] = OP_ADD; dsts[0] = 5'd6;
    exp_w[1] = 64'hFFFF_FFFF_FFFF_FFF9; ops[1] = OP_SUB; dsts[1] = 5'd7;
    exp_w[2] = 64'd4;   ops[2] = OP_AND; dsts[2] = 5'd8;
    exp_w[3] = 64'd13;  ops[3] = OP_ORR; dsts[3] = 5'd9;
    exp_w[4] = 64'd0;   ops[4] = OP_ADD; dsts[4] = 5'd31;
    run_instr(enc_d(OP_LDUR, 5'd4, 5'd31, 9'd0), 0, nc, nr);
    checks++;
    if (nc !== 5 || dMemOut !== 64'd5) begin
      errors++; $display("FAIL ldur_x4 got cyc=%0d dMemOut=%h want 5/5", nc, dMemOut);
    end
    run_instr(enc_d(OP_LDUR, 5'd5, 5'd31, 9'd32), 0, nc, nr);
    exp_pc += 64'd8;
    for (int i = 0; i < 5; i++) begin
      run_instr(enc_r(ops[i], dsts[i], 5'd4, 5'd5), 0, nc, nr);
      run_instr(enc_d(OP_STUR, dsts[i], 5'd31, 9'd40), 0, nc, nr);
      exp_pc += 64'd8;
      checks++;
      if (last_wdata !== exp_w[i]) begin
        errors++; $display("FAIL alu_%0d got %h want %h", i, last_wdata, exp_w[i]);
      end
    end
    // Negative offset: X4 (=5) + (-5) addresses word 0.
    run_instr(enc_d(OP_LDUR, 5'd10, 5'd4, 9'h1FB), 0, nc, nr);
    exp_pc += 64'd4;
    checks++;
    if (last_addr !== 64'd0 || dMemOut !== 64'd5) begin
      errors++; $display("FAIL ldur_negimm got addr=%h data=%h want 0/5", last_addr, dMemOut);
    end
    checks++;
    if (currentPC !== exp_pc) begin
      errors++; $display("FAIL alu_pc got %h want %h", currentPC, exp_pc);
    end
  endtask

  task automatic test_mem;
    int nc, nr;
    run_instr(enc_d(OP_LDUR, 5'd2, 5'd31, 9'd16), 0, nc, nr);
    run_instr(enc_d(OP_STUR, 5'd2, 5'd31, 9'd8), 0, nc, nr);
    checks++;
    if (nc !== 4 || last_addr !== 64'd8 || last_wdata !== 64'h10) begin
      errors++; $display("FAIL stur_x2 got cyc=%0d addr=%h data=%h want 4/8/10", nc,
                         last_addr, last_wdata);
    end
    run_instr(enc_d(OP_LDUR, 5'd11, 5'd31, 9'd0), 0, nc, nr);
    run_instr(enc_d(OP_LDUR, 5'd3, 5'd31, 9'd8), 3, nc, nr);
    checks++;
    if (nc !== 8 || nr !== 4) begin
      errors++; $display("FAIL ldur_wait got cyc=%0d req=%0d want 8/4", nc, nr);
    end
    checks++;
    if (dMemOut !== 64'h10) begin
      errors++; $display("FAIL ldur_wait_data got %h want %h", dMemOut, 64'h10);
    end
    run_instr(enc_d(OP_STUR, 5'd3, 5'd31, 9'd48), 0, nc, nr);
    checks++;
    if (last_wdata !== 64'h10) begin
      errors++; $display("FAIL x3_value got %h want %h", last_wdata, 64'h10);
    end
  endtask

  task automatic test_branch;
    int nc, nr;
    do_reset(64'h1FC);
    run_instr(enc_d(OP_LDUR, 5'd4, 5'd31, 9'd0), 0, nc, nr);
    run_instr(enc_cbz(5'd4, 19'h7FFFE), 0, nc, nr);
    checks++;
    if (nc !== 3 || currentPC !== 64'h204) begin
      errors++; $display("FAIL cbz_not_taken got cyc=%0d pc=%h want 3/204", nc, currentPC);
    end
    run_instr(enc_b(26'h3FF_FFFF), 0, nc, nr);
    checks++;
    if (nc !== 3 || currentPC !== 64'h200) begin
      errors++; $display("FAIL b_back got cyc=%0d pc=%h want 3/200", nc, currentPC);
    end
    run_instr(enc_cbz(5'd31, 19'h7FFFE), 0, nc, nr);
    checks++;
    if (nc !== 3 || currentPC !== 64'h1F8) begin
      errors++; $display("FAIL cbz_taken got cyc=%0d pc=%h want 3/1f8", nc, currentPC);
    end
    run_instr(enc_b(26'd4), 0, nc, nr);
    checks++;
    if (currentPC !== 64'h208) begin
      errors++; $display("FAIL b_fwd got pc=%h want 208", currentPC);
    end
  endtask

  task automatic test_halt;
    int nc, nr, bad;
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(enc_r(OP_ADD, 5'd1, 5'd31, 5'd31), 0, nc, nr);
    checks++;
    if (currentPC !== 64'h0) begin
      errors++; $display("FAIL pc_wrap got %h want 0", currentPC);
    end
    imem_rdata = 32'hFFE0_0000;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
      @(negedge CLK);
      #1;
    end
    checks++;
    if (bad !== 0 || currentPC !== 64'h0) begin
      errors++; $display("FAIL halt_quiet got bad=%0d pc=%h want 0/0", bad, currentPC);
    end
    Reset_L = 1'b0;
    startPC = 64'h300;
    #1;
    checks++;
    if (currentPC !== 64'h300 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset got pc=%h halted=%b want 300/0", currentPC, halted);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_resume got %b want 1", imem_req); end
    run_instr(enc_r(OP_ADD, 5'd1, 5'd31, 5'd31), 0, nc, nr);
    checks++;
    if (nc !== 4 || currentPC !== 64'h304) begin
      errors++; $display("FAIL after_halt got cyc=%0d pc=%h want 4/304", nc, currentPC);
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    do_reset(64'h400);
    imem_rdata = enc_d(OP_LDUR, 5'd1, 5'd31, 9'd0);
    dmem_ack   = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (dmem_req === 1'b1) found = 1'b1;
      else @(negedge CLK);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach_mem got 0 want 1"); end
    Reset_L = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || currentPC !== 64'h400) begin
      errors++; $display("FAIL mid_reset got req=%b we=%b pc=%h want 0/0/400", dmem_req,
                         dmem_we, currentPC);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
  endtask

  task automatic test_perf;
    int nc, nr;
`ifdef MCPROC_PERF_CNT_EN
    do_reset(64'h500);
    imem_rdata = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    repeat (40) @(posedge CLK);
    #1;
    checks++;
    if (instr_cnt !== 32'd10 || cycle_cnt !== 32'd40) begin
      errors++; $display("FAIL perf_cnt got ins=%0d cyc=%0d want 10/40", instr_cnt, cycle_cnt);
    end
    @(negedge CLK);
`else
    do_reset(64'h500);
    for (int i = 0; i < 3; i++) run_instr(enc_r(OP_ADD, 5'd1, 5'd2, 5'd3), 0, nc, nr);
    checks++;
    if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_off got ins=%0d cyc=%0d want 0/0", instr_cnt, cycle_cnt);
    end
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset_L    = 1'b0;
    startPC    = 64'h100;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 64'h0;
    last_addr  = 64'h0;
    last_wdata = 64'h0;
    exp_pc     = 64'h0;
    for (int i = 0; i < 16; i++) mem[i] = 64'h0;
    mem[0] = 64'd5;
    mem[2] = 64'h10;
    mem[4] = 64'd12;

    test_reset();
    test_add();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_reset_mid();
    test_perf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_proc.md
MULTI_CYCLE_PROC -- requirements
Module: multi_cycle_proc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the datapath, register and PC width (legal values 32 and 64).
REQ-002 The block SHALL have parameter NREGS, default 32, giving the register count (power of two, 8..32); register NREGS-1 is the zero register.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset_L, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port startPC, input, DATA_W bits: PC value loaded on reset.
REQ-006 The block SHALL have port currentPC, output, DATA_W bits: address of the instruction in progress.
REQ-007 The block SHALL have ports imem_req (out, 1), imem_ack (in, 1) and imem_rdata (in, 32): the instruction fetch handshake; the fetch address is currentPC.
REQ-008 The block SHALL have ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, DATA_W), dmem_wdata (out, DATA_W), dmem_rdata (in, DATA_W) and dmem_ack (in, 1): the data memory handshake.
REQ-009 The block SHALL have port dMemOut, output, DATA_W bits: the last loaded data word.
REQ-010 The block SHALL have ports retire (out, 1), a one-cycle pulse per completed instruction, and halted (out, 1), set in HALT.
REQ-011 The block SHALL have ports cycle_cnt (out, 32) and instr_cnt (out, 32): the performance counters defined by REQ-026.

Function
REQ-012 The controller SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-013 In FETCH, imem_req SHALL be held high until a cycle in which imem_ack=1; in that cycle the instruction is latched and the next state is DECODE.
REQ-014 In DECODE, registers Rn and Rm SHALL be read; for STUR and CBZ the second operand SHALL be Rt (the bits [4:0] field).
REQ-015 The supported opcodes SHALL be: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100, B 000101.
REQ-016 Any other opcode SHALL take DECODE to HALT: halted=1, no memory requests and no register or PC change until reset.
REQ-017 In EXEC, the arithmetic SHALL be modulo 2^DATA_W; LDUR/STUR address = Rn + sign-extended imm9 [20:12].
REQ-018 In EXEC, branches SHALL resolve and return to FETCH with no WB state.
REQ-019 A taken CBZ (Rt==0) SHALL set PC = PC + (sext(imm19)<<2); B SHALL set PC = PC + (sext(imm26)<<2); every other instruction SHALL set PC = PC+4, wrapping modulo 2^DATA_W.
REQ-020 In MEM, dmem_req SHALL be held high, with address, data and we held stable, until the cycle in which dmem_ack=1; STUR then returns to FETCH, LDUR proceeds to WB.
REQ-021 In WB, the register write SHALL occur, with loads also updating dMemOut; writes to the zero register SHALL be discarded, and reads of it SHALL return 0.
REQ-022 Minimum latency with zero-wait acks SHALL be: B/CBZ 3 cycles, R-type 4, STUR 4, LDUR 5.
REQ-023 retire SHALL pulse in the last cycle of each instruction.
REQ-024 An ack arriving while the corresponding req is low SHALL be ignored.

Reset
REQ-025 While Reset_L=0, all of the following SHALL hold immediately: currentPC=startPC, state=FETCH, imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0, dMemOut=0, all registers 0, counters 0; reset mid-handshake abandons the transaction.

Configuration
REQ-026 With macro MCPROC_PERF_CNT_EN defined, cycle_cnt SHALL increment every non-HALT cycle and instr_cnt SHALL increment on each retire, both wrapping at 2^32; without it, both SHALL be tied to 0 and no counter flops exist.

Verification
REQ-027 The bench SHALL cover: reset with startPC=0x100, then ADD X1,X31,X31 with zero-wait acks -> retire at cycle 4, currentPC=0x104, X1=0.
REQ-028 The bench SHALL cover: X2=0x10 and STUR X2,[X31,#8], then LDUR X3,[X31,#8] with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, X3=0x10, dMemOut=0x10, LDUR takes 8 cycles.
REQ-029 The bench SHALL cover: CBZ X31,#-2 at PC 0x200 -> PC=0x1F8 after 3 cycles; CBZ with a nonzero Rt -> PC=0x204.
REQ-030 The bench SHALL cover: opcode 0x7FF -> HALT, halted=1, no imem_req for 20 cycles; Reset_L pulse -> PC=startPC, fetch resumes.
REQ-031 The bench SHALL cover: Reset_L dropped during MEM with dmem_req=1 -> dmem_req=0 before the next CLK edge.
REQ-032 The bench SHALL cover: with MCPROC_PERF_CNT_EN defined, 10 ADDs with zero-wait acks -> instr_cnt=10, cycle_cnt=40; without the macro, both counters read 0.
